// File: rtl/rdptr_lvl.sv
// Read-side pointer, fill-level and status controller for a dual-clock FIFO.
// Define RDPTR_SYNC_EN to add a 2-flop synchroniser on the incoming Gray write pointer.
module rdptr_lvl #(
  parameter int PTR_WIDTH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 r_en,
  input  logic                 uf_clr,
  input  logic [PTR_WIDTH:0]   g_wptr_sync,
  output logic                 rd_fire,
  output logic [PTR_WIDTH:0]   b_rptr,
  output logic [PTR_WIDTH:0]   g_rptr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   rd_level,
  output logic                 underflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_L = {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [PTR_WIDTH:0] AE_L    = (PTR_WIDTH+1)'(AE_THRESH);

  logic [PTR_WIDTH:0] w_gw;
  logic [PTR_WIDTH:0] w_bw;
  logic [PTR_WIDTH:0] w_b_next;
  logic [PTR_WIDTH:0] w_g_next;
  logic [PTR_WIDTH:0] w_lvl_raw;
  logic [PTR_WIDTH:0] w_lvl_next;
  logic               w_empty_next;
  logic               w_ae_next;

`ifdef RDPTR_SYNC_EN
  logic [PTR_WIDTH:0] r_sync1;
  logic [PTR_WIDTH:0] r_sync2;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= g_wptr_sync;
      r_sync2 <= r_sync1;
    end
  end

  assign w_gw = r_sync2;
`else
  assign w_gw = g_wptr_sync;
`endif

  assign rd_fire  = r_en & ~empty;
  assign w_b_next = b_rptr + {{PTR_WIDTH{1'b0}}, rd_fire};
  assign w_g_next = w_b_next ^ (w_b_next >> 1);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bw = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) begin
      w_bw[i] = ^(w_gw >> i);
    end
  end

  // A level above DEPTH only arises from a corrupt write pointer; clamp it.
  assign w_lvl_raw    = w_bw - w_b_next;
  assign w_lvl_next   = (w_lvl_raw > DEPTH_L) ? DEPTH_L : w_lvl_raw;
  assign w_empty_next = (w_g_next == w_gw);
  assign w_ae_next    = (w_lvl_next <= AE_L);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      rd_level     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      b_rptr       <= w_b_next;
      g_rptr       <= w_g_next;
      rd_level     <= w_lvl_next;
      empty        <= w_empty_next;
      almost_empty <= w_ae_next;
      // Set has priority over clear so a coincident underflow is never lost.
      if (r_en & empty)
        underflow <= 1'b1;
      else if (uf_clr)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rdptr_lvl.sv
// Bench for rdptr_lvl: directed vector table, hand sequences and a randomized run
// checked against a count-based model of the FIFO read side.
module tb_rdptr_lvl;

`ifdef RDPTR_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif
  localparam int SETTLE = 1 + LAG;

  logic       rclk;
  logic       rrst;
  logic       r_en;
  logic       uf_clr;
  logic [3:0] g_wptr_sync;
  logic       rd_fire;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;
  logic       underflow;

  rdptr_lvl #(.PTR_WIDTH(3), .AE_THRESH(1)) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .r_en        (r_en),
    .uf_clr      (uf_clr),
    .g_wptr_sync (g_wptr_sync),
    .rd_fire     (rd_fire),
    .b_rptr      (b_rptr),
    .g_rptr      (g_rptr),
    .empty       (empty),
    .almost_empty(almost_empty),
    .rd_level    (rd_level),
    .underflow   (underflow)
  );

  // clock / reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: read count, effective write count, flags
  int m_b, m_lvl, m_empty, m_ae, m_uf, m_s1, m_s2;
  int w_drv;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_b = 0; m_lvl = 0; m_empty = 1; m_ae = 1; m_uf = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_step(input int r, input int c, input int wd);
    int gw_eff, raw, old_empty, fire;
    gw_eff    = (LAG == 2) ? m_s2 : (wd & 15);
    old_empty = m_empty;
    fire      = (r != 0 && m_empty == 0) ? 1 : 0;
    m_b       = (m_b + fire) % 16;
    raw       = (gw_eff - m_b + 16) % 16;
    m_lvl     = (raw > 8) ? 8 : raw;
    m_empty   = (raw == 0) ? 1 : 0;
    m_ae      = (m_lvl <= 1) ? 1 : 0;
    m_uf      = ((r != 0 && old_empty != 0) || (m_uf != 0 && c == 0)) ? 1 : 0;
    m_s2      = m_s1;
    m_s1      = wd & 15;
  endtask

  // driver: apply inputs after the falling edge, check rd_fire, step through one rising edge
  task automatic cycle(input int r, input int c, input int wd);
    r_en        = (r != 0);
    uf_clr      = (c != 0);
    g_wptr_sync = gray(wd);
    #1;
    chk("rd_fire", int'(rd_fire), (r != 0 && m_empty == 0) ? 1 : 0);
    @(posedge rclk);
    model_step(r, c, wd);
    @(negedge rclk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_b"},     int'(b_rptr),       m_b);
    chk({tag, "_g"},     int'(g_rptr),       int'(gray(m_b)));
    chk({tag, "_lvl"},   int'(rd_level),     m_lvl);
    chk({tag, "_empty"}, int'(empty),        m_empty);
    chk({tag, "_ae"},    int'(almost_empty), m_ae);
    chk({tag, "_uf"},    int'(underflow),    m_uf);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_b"},     int'(b_rptr),       0);
    chk({tag, "_g"},     int'(g_rptr),       0);
    chk({tag, "_lvl"},   int'(rd_level),     0);
    chk({tag, "_empty"}, int'(empty),        1);
    chk({tag, "_ae"},    int'(almost_empty), 1);
    chk({tag, "_uf"},    int'(underflow),    0);
  endtask

  typedef struct {
    int w;   // write pointer, binary
    int r;
    int c;
    int eb;
    int el;
    int ee;
    int ea;
    int eu;
  } vec_t;

  vec_t vt[15];

  initial begin
    int prev_b, wrapped, lat, i;

    // w, r, c, exp b, lvl, empty, ae, uf  (starting from b=0 after reset)
    vt[0]  = '{3,  0, 0, 0, 3, 0, 0, 0};
    vt[1]  = '{3,  1, 0, 1, 2, 0, 0, 0};
    vt[2]  = '{3,  1, 0, 2, 1, 0, 1, 0};
    vt[3]  = '{3,  1, 0, 3, 0, 1, 1, 0};
    vt[4]  = '{3,  1, 0, 3, 0, 1, 1, 1};
    vt[5]  = '{3,  0, 0, 3, 0, 1, 1, 1};
    vt[6]  = '{3,  1, 1, 3, 0, 1, 1, 1};
    vt[7]  = '{3,  0, 1, 3, 0, 1, 1, 0};
    vt[8]  = '{11, 0, 0, 3, 8, 0, 0, 0};
    vt[9]  = '{11, 1, 0, 4, 7, 0, 0, 0};
    vt[10] = '{15, 0, 0, 4, 8, 0, 0, 0};
    vt[11] = '{4,  0, 0, 4, 0, 1, 1, 0};
    vt[12] = '{5,  0, 0, 4, 1, 0, 1, 0};
    vt[13] = '{5,  1, 0, 5, 0, 1, 1, 0};
    vt[14] = '{13, 0, 0, 5, 8, 0, 0, 0};

    rrst = 1'b1; r_en = 1'b0; uf_clr = 1'b0; g_wptr_sync = 4'b0000;
    repeat (3) @(negedge rclk);
    rrst = 1'b0;
    #1;
    chk_reset_vals("reset");
    model_reset();
    w_drv = 0;

    // directed vector table; idle cycles let the write pointer settle first
    for (int k = 0; k < 15; k++) begin
      repeat (SETTLE) cycle(0, 0, vt[k].w);
      cycle(vt[k].r, vt[k].c, vt[k].w);
      chk($sformatf("v%0d_b", k),     int'(b_rptr),       vt[k].eb);
      chk($sformatf("v%0d_g", k),     int'(g_rptr),       int'(gray(vt[k].eb)));
      chk($sformatf("v%0d_lvl", k),   int'(rd_level),     vt[k].el);
      chk($sformatf("v%0d_empty", k), int'(empty),        vt[k].ee);
      chk($sformatf("v%0d_ae", k),    int'(almost_empty), vt[k].ea);
      chk($sformatf("v%0d_uf", k),    int'(underflow),    vt[k].eu);
    end

    // wrap-around: stream reads with the write pointer leading by 2
    w_drv = m_b + 2 + LAG;
    repeat (SETTLE) cycle(0, 0, w_drv);
    wrapped = 0;
    for (int k = 0; k < 20; k++) begin
      prev_b = int'(b_rptr);
      w_drv++;
      cycle(1, 0, w_drv);
      chk_model("wrap");
      if (k >= LAG) begin
        chk("wrap_lvl2", int'(rd_level), 2);
        chk("wrap_nonempty", int'(empty), 0);
      end
      if (prev_b == 15 && b_rptr == 4'd0) wrapped = 1;
    end
    chk("wrap_seen", wrapped, 1);

    // randomized traffic
    w_drv = m_b;
    repeat (SETTLE) cycle(0, 0, w_drv);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1 && ((w_drv - m_b) & 15) < 8) w_drv++;
      cycle(($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0, w_drv);
      chk_model("rand");
    end

    // mid-operation asynchronous reset at level 5
    w_drv = m_b + 5;
    repeat (SETTLE) cycle(0, 0, w_drv);
    chk("pre_rst_lvl", int'(rd_level), 5);
    #2 rrst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    g_wptr_sync = 4'b0000;
    @(negedge rclk);
    rrst = 1'b0;
    model_reset();
    w_drv = 0;
    cycle(0, 0, 0);
    chk_model("post_rst");

    // latency from a write-pointer change to empty deassertion
    lat = 0;
    i = 0;
    while (i < 10 && lat == 0) begin
      cycle(0, 0, 1);
      i++;
      if (empty == 1'b0) lat = i;
    end
    chk("empty_latency", lat, 1 + LAG);
    chk_model("lat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rdptr_lvl.md
Name: rdptr_lvl

Overview:
Parametrised read-side pointer and status controller for the dual-clock FIFO. It is the next generation of the basic read-pointer/empty block.
- Keeps binary and Gray read pointers and registered empty, as before.
- Adds fill-level reporting, a programmable almost-empty flag, a sticky underflow flag, and an optionally compiled-in Gray write-pointer synchroniser.
- Sits in the read clock domain, between the FIFO memory read port and the read-side consumer.

Parameters:
PTR_WIDTH, 3, address bits; FIFO depth DEPTH = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits wide.
AE_THRESH, 1, almost_empty asserts when fill level <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
rclk  input  1  read-domain clock, rising edge.
rrst  input  1  asynchronous, active-high reset.
r_en  input  1  read request from consumer.
uf_clr  input  1  clears the sticky underflow flag.
g_wptr_sync  input  PTR_WIDTH+1  Gray write pointer (already synchronised unless RDPTR_SYNC_EN).
rd_fire  output  1  combinational r_en & ~empty; memory read strobe.
b_rptr  output  PTR_WIDTH+1  binary read pointer, registered; low PTR_WIDTH bits are the memory address.
g_rptr  output  PTR_WIDTH+1  Gray read pointer, registered; goes to the write-domain synchroniser.
empty  output  1  registered empty flag.
almost_empty  output  1  registered almost-empty flag.
rd_level  output  PTR_WIDTH+1  registered fill level, 0..DEPTH.
underflow  output  1  sticky flag; set by a read attempt while empty.

Behaviour:
- Reset (rrst high, asynchronous, wins over everything):
  - b_rptr=0, g_rptr=0, rd_level=0, underflow=0.
  - empty=1, almost_empty=1.
  - Any synchroniser flops = 0.
- Let gw denote the write pointer the block uses: g_wptr_sync directly, or the synchroniser output when RDPTR_SYNC_EN is defined.
- Next-state logic, evaluated every cycle:
  - rd_fire = r_en & ~empty.
  - b_next = b_rptr + rd_fire, modulo 2**(PTR_WIDTH+1); wraps from all-ones to 0.
  - g_next = b_next ^ (b_next >> 1).
  - bw = Gray-to-binary of gw: MSB passes through; each lower bit = bw[i+1] ^ gw[i].
  - lvl_next = (bw - b_next) modulo 2**(PTR_WIDTH+1).
  - empty_next = (g_next == gw).
  - ae_next = (lvl_next <= AE_THRESH).
- Registered outputs:
  - On each rclk rising edge, b_rptr, g_rptr, rd_level, empty and almost_empty load their next values.
  - Latency: one cycle from a gw change or a read to the flag and level update.
- Read while empty (r_en=1 with empty=1):
  - rd_fire=0; the pointers hold.
  - underflow sets on the next edge.
- Underflow flag:
  - uf_clr clears underflow on the next edge.
  - A set and a clear in the same cycle leave underflow=1 (set wins).
- Read on the last entry (rd_fire=1 and lvl_next==0): empty=1 on the next edge. No bubble; a back-to-back read is then blocked.
- Simultaneous write-pointer advance and read: level stays constant, computed from b_next.
- Level above DEPTH:
  - Only possible with a corrupt gw. rd_level saturates to DEPTH.
  - Flags follow the computed lvl_next==0 / threshold rules with the saturated value.
- Full FIFO: rd_level=DEPTH, empty=0, almost_empty=0.
- Reset asserted mid-read: all state returns to reset values immediately. The first read after release needs empty=0, which takes one rclk edge after gw differs from 0.

Optional Feature:
RDPTR_SYNC_EN
- Defined:
  - g_wptr_sync is the raw write-domain Gray pointer.
  - It passes through a 2-flop synchroniser clocked by rclk and reset by rrst to 0; gw = second flop.
  - empty deassertion and level increase each gain 2 cycles of latency. Everything else is unchanged.
- Undefined: gw = g_wptr_sync with no extra flops.

Test Plan:
- Reset: hold rrst high 3 cycles, then release -> empty=1, almost_empty=1, rd_level=0, b_rptr=0, g_rptr=0, underflow=0.
- Fill then drain (PTR_WIDTH=3, AE_THRESH=1):
  - Stimulus: g_wptr_sync steps to 4'b0010 (binary 3).
  - Next edge -> empty=0, rd_level=3, almost_empty=0.
  - Hold r_en=1 for 3 cycles -> rd_level goes 2 then 1, almost_empty=1 at level 1; after the third read empty=1 and rd_level=0, with b_rptr=3 and g_rptr=4'b0010.
- Underflow: with empty=1, pulse r_en for 1 cycle -> b_rptr unchanged, underflow=1 and stays 1. Then assert uf_clr and r_en together -> underflow stays 1. Then uf_clr alone -> underflow=0.
- Wrap-around: stream 20 writes and reads, with the write pointer leading by 2 -> b_rptr passes 15->0 and g_rptr passes 4'b1000->4'b0000; rd_level stays 2 and empty stays 0 throughout.
- Full: g_wptr_sync=4'b1100 (binary 8) with b_rptr=0 -> rd_level=8, empty=0, almost_empty=0.
- Mid-operation reset: assert rrst asynchronously between edges while rd_level=5 -> all outputs take reset values before the next edge. With RDPTR_SYNC_EN defined, empty deasserts 3 edges after a gw change instead of 1.
